dot_accumulator: RTL and testbench

//  Downstream stage of the two-product multiply-add pipeline. Consumes its 32-bit
//  per-cycle result (A1*B1 + A2*B2) as a tagged stream and accumulates the terms of one

---
 rtl/dot_accumulator_pkg.sv | 15 +
 rtl/dot_accumulator_sat_counter.sv | 43 ++++
 rtl/dot_accumulator.sv | 127 ++++++++++++
 tb/tb_dot_accumulator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dot_accumulator_pkg.sv
// Shared types and default widths for the multiply-add stream stages.
// The 32-bit input width must match the upstream multiply-add C output.
package dot_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_IN_W  = 32;
    localparam int DEF_ACC_W = 40;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/dot_accumulator_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// It exposes the next count so a consumer can capture it in the same cycle as the increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_next,
    output logic             sat_hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    always_comb begin
        at_max  = (cnt_q == {CNT_W{1'b1}});
        cnt_d   = cnt_q;
        sat_hit = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (at_max) begin
                sat_hit = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign cnt_next = cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates a tagged stream of unsigned partial sums into one dot-product result.
// The result is offered on a valid/ready output together with a term count and a sticky overflow flag.
module dot_accumulator
    import dot_accumulator_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int SUM_W = ACC_W + 1;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             release_result;
    logic [SUM_W-1:0] sum_w;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_sat_hit;

    assign in_ready       = (state_q != HOLD);
    assign accept         = in_valid & in_ready;
    assign release_result = (state_q == HOLD) & out_ready;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (release_result),
        .en      (accept),
        .cnt_next(cnt_next),
        .sat_hit (cnt_sat_hit)
    );

    // The first term of a vector starts from zero so nothing left over in acc can leak in.
    always_comb begin
        if (state_q == IDLE) begin
            sum_w    = SUM_W'(in_data);
            ovf_next = cnt_sat_hit;
        end else begin
            sum_w    = SUM_W'(acc_q) + SUM_W'(in_data);
            ovf_next = ovf_q | sum_w[ACC_W] | cnt_sat_hit;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = sum_w[ACC_W-1:0];
                    ovf_d = ovf_next;
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_sum_d   = sum_w[ACC_W-1:0];
                        out_count_d = cnt_next;
                        out_ovf_d   = ovf_next;
                        state_d     = HOLD;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator, built with a 33-bit accumulator and a 2-bit counter.
// These widths let wrap-around and count saturation be reached with short vectors.
module tb_dot_accumulator;

    localparam int IN_W  = 32;
    localparam int ACC_W = 33;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int checks;
    int errors;

    dot_accumulator #(
        .IN_W (IN_W),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0][31:0] terms;
        logic [2:0]       n;
        logic [32:0]      exp_sum;
        logic [1:0]       exp_count;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents terms one per cycle; returns #1 after the edge that accepted the final term.
    task automatic send_vec(input logic [4:0][31:0] t, input int n, input logic close);
        for (int i = 0; i < n; i++) begin
            int waited;
            bit done;
            in_valid = 1'b1;
            in_data  = t[i];
            in_last  = close && (i == n - 1);
            waited   = 0;
            done     = 1'b0;
            while (!done) begin
                if (in_ready) begin
                    tick();
                    done = 1'b1;
                end else if (waited >= 20) begin
                    check("accept_timeout", 64'(waited), 64'd0);
                    done = 1'b1;
                end else begin
                    tick();
                    waited++;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [32:0] s,
                                input logic [1:0] c, input logic o);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"},   64'(out_sum),   64'(s));
        check({tag, "_count"}, 64'(out_count), 64'(c));
        check({tag, "_ovf"},   64'(out_ovf),   64'(o));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd123;
        in_last   = 1'b1;
        out_ready = 1'b1;

        vecs[0] = '{terms: {32'd0, 32'd0, 32'd30, 32'd20, 32'd10}, n: 3'd3,
                    exp_sum: 33'd60, exp_count: 2'd3, exp_ovf: 1'b0};
        vecs[1] = '{terms: {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, n: 3'd3,
                    exp_sum: 33'h0_FFFF_FFFD, exp_count: 2'd3, exp_ovf: 1'b1};
        vecs[2] = '{terms: {32'd0, 32'd0, 32'd0, 32'd0, 32'd1}, n: 3'd1,
                    exp_sum: 33'd1, exp_count: 2'd1, exp_ovf: 1'b0};
        vecs[3] = '{terms: {32'd1, 32'd1, 32'd1, 32'd1, 32'd1}, n: 3'd5,
                    exp_sum: 33'd5, exp_count: 2'd3, exp_ovf: 1'b1};
        vecs[4] = '{terms: {32'd0, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF}, n: 3'd2,
                    exp_sum: 33'h1_0000_0000, exp_count: 2'd2, exp_ovf: 1'b0};
        vecs[5] = '{terms: {32'd0, 32'd0, 32'd0, 32'd3, 32'd4}, n: 3'd2,
                    exp_sum: 33'd7, exp_count: 2'd2, exp_ovf: 1'b0};

        // Reset held two cycles while traffic is offered.
        tick();
        tick();
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_result", 64'(out_valid), 64'd0);
        end

        // Table-driven vectors with an always-ready consumer.
        for (int v = 0; v < 6; v++) begin
            send_vec(vecs[v].terms, int'(vecs[v].n), 1'b1);
            check_result($sformatf("vec%0d", v), vecs[v].exp_sum,
                         vecs[v].exp_count, vecs[v].exp_ovf);
            check($sformatf("vec%0d_hold_ready", v), 64'(in_ready), 64'd0);
            tick();
            check($sformatf("vec%0d_released", v), 64'(out_valid), 64'd0);
            check($sformatf("vec%0d_idle_ready", v), 64'(in_ready), 64'd1);
        end

        // Backpressure: result must stay put and no new term may slip in.
        out_ready = 1'b0;
        send_vec({32'd0, 32'd0, 32'd0, 32'd0, 32'd7}, 1, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'd5;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_result("bp_hold", 33'd7, 2'd1, 1'b0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_released", 64'(out_valid), 64'd0);
        check("bp_idle_ready", 64'(in_ready), 64'd1);
        send_vec({32'd0, 32'd0, 32'd0, 32'd5, 32'd5}, 2, 1'b1);
        check_result("bp_next", 33'd10, 2'd2, 1'b0);
        tick();

        // Reset in the middle of a vector discards the partial sum.
        send_vec({32'd0, 32'd0, 32'd0, 32'd200, 32'd100}, 2, 1'b0);
        check("mid_no_result", 64'(out_valid), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        send_vec({32'd0, 32'd0, 32'd0, 32'd0, 32'd4}, 1, 1'b1);
        check_result("mid_after", 33'd4, 2'd1, 1'b0);
        tick();
        check("mid_no_stale", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
